// File: rtl/gate_exerciser.sv
// Two-input gate exerciser: applies the four (A,B) vectors to an external gate,
// waits SETTLE cycles, samples X against the selected gate function and reports.
module gate_exerciser #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [2:0] SEL,
    output logic       A,
    output logic       B,
    input  logic       X,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] ERR_CNT,
    output logic [3:0] FAIL_MASK
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_REPORT
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     r_state;
    logic [2:0] r_sel;
    logic [1:0] r_vec;
    logic [3:0] r_wait;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_mask;

    logic       w_expect;
    logic       w_mismatch;
    logic [2:0] w_err_next;
    logic [1:0] w_vec_next;

    always_comb begin
        w_expect = 1'b0;
        case (r_sel)
            3'd0:    w_expect = r_a & r_b;
            3'd1:    w_expect = r_a | r_b;
            3'd2:    w_expect = ~(r_a & r_b);
            3'd3:    w_expect = ~(r_a | r_b);
            3'd4:    w_expect = r_a ^ r_b;
            3'd5:    w_expect = ~(r_a ^ r_b);
            3'd6:    w_expect = ~r_a;
            default: w_expect = r_a;
        endcase
    end

    assign w_mismatch = (X != w_expect);
    // Saturate so the count can never wrap past the number of vectors.
    assign w_err_next = (w_mismatch && (r_err != 3'd4)) ? r_err + 3'd1 : r_err;
    assign w_vec_next = r_vec + 2'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_vec   <= '0;
            r_wait  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_a    <= 1'b0;
                    r_b    <= 1'b0;
                    r_done <= 1'b0;
                    if (START) begin
                        r_sel   <= SEL;
                        r_err   <= '0;
                        r_mask  <= '0;
                        r_pass  <= 1'b0;
                        r_vec   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    r_wait  <= SETTLE_L;
                    r_state <= (SETTLE_L != 4'd0) ? S_WAIT : S_SAMPLE;
                end
                S_WAIT: begin
                    r_wait <= r_wait - 4'd1;
                    if (r_wait <= 4'd1) r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch) r_mask[r_vec] <= 1'b1;
                    if (r_vec == 2'd3) begin
                        // PASS/DONE are registered here so they are valid during REPORT.
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 3'd0);
                        r_state <= S_REPORT;
                    end else begin
                        r_vec   <= w_vec_next;
                        r_a     <= w_vec_next[1];
                        r_b     <= w_vec_next[0];
                        r_state <= S_APPLY;
                    end
                end
                S_REPORT: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign ERR_CNT   = r_err;
    assign FAIL_MASK = r_mask;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench: two exercisers (SETTLE=2 and SETTLE=0) driving a modelled gate.
module tb_gate_exerciser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i [2];
    logic [2:0] sel_i   [2];
    logic       x_i     [2];
    logic       a_o     [2];
    logic       b_o     [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       pass_o  [2];
    logic [2:0] ec_o    [2];
    logic [3:0] fm_o    [2];
    int         xm      [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gate_exerciser #(.SETTLE(2)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start_i[0]), .SEL(sel_i[0]),
        .A(a_o[0]), .B(b_o[0]), .X(x_i[0]), .BUSY(busy_o[0]), .DONE(done_o[0]),
        .PASS(pass_o[0]), .ERR_CNT(ec_o[0]), .FAIL_MASK(fm_o[0])
    );

    gate_exerciser #(.SETTLE(0)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start_i[1]), .SEL(sel_i[1]),
        .A(a_o[1]), .B(b_o[1]), .X(x_i[1]), .BUSY(busy_o[1]), .DONE(done_o[1]),
        .PASS(pass_o[1]), .ERR_CNT(ec_o[1]), .FAIL_MASK(fm_o[1])
    );

    // Gate model: 0 A|B, 1 stuck-0, 2 NAND, 3 A, 4 stuck-1, 5 A^B
    function automatic logic xf(int m, logic a, logic b);
        case (m)
            0:       return a | b;
            1:       return 1'b0;
            2:       return ~(a & b);
            3:       return a;
            4:       return 1'b1;
            5:       return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    assign x_i[0] = xf(xm[0], a_o[0], b_o[0]);
    assign x_i[1] = xf(xm[1], a_o[1], b_o[1]);

    function automatic logic [11:0] outs(int d);
        return {a_o[d], b_o[d], busy_o[d], done_o[d], pass_o[d], ec_o[d], fm_o[d]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         d;
        logic [2:0] sel;
        int         xmode;
        int         ec;
        logic [3:0] fm;
        logic       pass;
    } vec_t;

    vec_t tbl [11];

    task automatic run(vec_t t);
        int  d;
        int  settle;
        int  n;
        int  v;
        logic ab_ok;
        logic [1:0] vv;
        d      = t.d;
        settle = (d == 0) ? 2 : 0;
        @(negedge clk);
        sel_i[d]   = t.sel;
        xm[d]      = t.xmode;
        start_i[d] = 1'b1;
        @(posedge clk);
        #1;
        start_i[d] = 1'b0;
        sel_i[d]   = ~t.sel;
        @(negedge clk);
        chk("busy_start", busy_o[d], 1'b1);
        ab_ok = ({a_o[d], b_o[d]} == 2'b00);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_o[d]) break;
            v  = n / (settle + 2);
            vv = 2'(v);
            if ({a_o[d], b_o[d]} !== vv) ab_ok = 1'b0;
        end
        chk("ab_seq", ab_ok, 1'b1);
        chk("latency", n, 4 * (settle + 2));
        chk("err_cnt", ec_o[d], t.ec);
        chk("fail_mask", fm_o[d], t.fm);
        chk("pass", pass_o[d], t.pass);
        @(negedge clk);
        chk("done_pulse", done_o[d], 1'b0);
        chk("busy_end", busy_o[d], 1'b0);
        chk("ab_idle", {a_o[d], b_o[d]}, 2'b00);
        chk("hold_mask", fm_o[d], t.fm);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            sel_i[i]   = '0;
            xm[i]      = 0;
        end
        #1;
        chk("reset_d0", outs(0), 12'h000);
        chk("reset_d1", outs(1), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{0, 3'd1, 0, 0, 4'b0000, 1'b1};
        tbl[1]  = '{0, 3'd1, 1, 3, 4'b1110, 1'b0};
        tbl[2]  = '{0, 3'd4, 0, 1, 4'b1000, 1'b0};
        tbl[3]  = '{0, 3'd0, 0, 2, 4'b0110, 1'b0};
        tbl[4]  = '{0, 3'd2, 2, 0, 4'b0000, 1'b1};
        tbl[5]  = '{0, 3'd3, 1, 1, 4'b0001, 1'b0};
        tbl[6]  = '{0, 3'd5, 4, 2, 4'b0110, 1'b0};
        tbl[7]  = '{0, 3'd4, 5, 0, 4'b0000, 1'b1};
        tbl[8]  = '{1, 3'd6, 3, 4, 4'b1111, 1'b0};
        tbl[9]  = '{1, 3'd7, 3, 0, 4'b0000, 1'b1};
        tbl[10] = '{1, 3'd0, 4, 3, 4'b0111, 1'b0};

        for (int i = 0; i < 11; i++) run(tbl[i]);

        // Re-pulse START and change SEL while busy: one DONE, NAND still in force.
        @(negedge clk);
        sel_i[0] = 3'd2; xm[0] = 2; start_i[0] = 1'b1;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start_i[0] = 1'b0;
            if (n == 3 || n == 9) begin start_i[0] = 1'b1; sel_i[0] = 3'd0; end
            if (n == 4 || n == 10) start_i[0] = 1'b0;
            @(negedge clk);
            if (done_o[0]) dones++;
        end
        chk("repulse_dones", dones, 1);
        chk("repulse_pass", pass_o[0], 1'b1);

        // START held high: runs complete at edges 16 and 34 within a 40-edge window.
        @(negedge clk);
        sel_i[0] = 3'd1; xm[0] = 0; start_i[0] = 1'b1;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_o[0]) dones++;
        end
        chk("held_dones", dones, 2);
        start_i[0] = 1'b0;
        for (int n = 0; n < 100 && busy_o[0]; n++) @(negedge clk);
        chk("held_idle", busy_o[0], 1'b0);

        // Reset during WAIT of vector 2 (edges 9-10 after acceptance).
        @(negedge clk);
        sel_i[0] = 3'd1; xm[0] = 1; start_i[0] = 1'b1;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        for (int n = 0; n < 9; n++) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_state", {a_o[0], b_o[0], ec_o[0], fm_o[0]}, {2'b10, 3'd1, 4'b0010});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_midrun", outs(0), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done_o[0] || busy_o[0]) dones++;
        end
        chk("no_done_after_rst", dones, 0);

        // First START after reset is honoured on the first edge it is high.
        start_i[0] = 1'b1;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        chk("start_after_rst", busy_o[0], 1'b1);
        for (int n = 0; n < 100 && busy_o[0]; n++) @(negedge clk);
        chk("final_pass", pass_o[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_exerciser.md
GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2: wait cycles between applying a vector and sampling X, legal range 0..15.
REQ-002 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 START  in  1  run request, sampled on CLK.
REQ-005 SEL  in  3  gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT-A (B ignored), 7 BUF-A (B ignored).
REQ-006 A  out  1  registered stimulus to device-under-test input A.
REQ-007 B  out  1  registered stimulus to device-under-test input B.
REQ-008 X  in  1  device-under-test output; combinational response to A, B.
REQ-009 BUSY  out  1  high in every state except IDLE.
REQ-010 DONE  out  1  single-cycle pulse when a run completes.
REQ-011 PASS  out  1  level; high when the last completed run had zero mismatches.
REQ-012 ERR_CNT  out  3  mismatch count of the current or last run, 0..4.
REQ-013 FAIL_MASK  out  4  bit i set when vector i mismatched.

Function
REQ-014 The FSM SHALL have states IDLE, APPLY, WAIT, SAMPLE, REPORT.
REQ-015 IDLE: A=B=0; START=1 SHALL latch SEL into an internal register, clear ERR_CNT, FAIL_MASK and PASS, set vector index to 0, and go to APPLY.
REQ-016 START SHALL be ignored in every state other than IDLE; SEL changes after acceptance SHALL have no effect on the run.
REQ-017 Vector index v (2 bits) SHALL drive A=v[1], B=v[0]; A and B SHALL change only on the edge entering APPLY and hold until the next vector is applied.
REQ-018 APPLY: one cycle; load the wait counter with SETTLE; go to WAIT if SETTLE>0, else go to SAMPLE.
REQ-019 WAIT: the wait counter SHALL decrement each cycle; go to SAMPLE on the cycle the counter reaches 1, so WAIT lasts exactly SETTLE cycles.
REQ-020 SAMPLE: one cycle; X SHALL be compared to the expected value of the latched gate at (A,B).
REQ-021 On a mismatch in SAMPLE, ERR_CNT SHALL increment by 1 and FAIL_MASK[v] SHALL be set.
REQ-022 Leaving SAMPLE: if v=3, go to REPORT; otherwise v increments and the FSM goes to APPLY.
REQ-023 Each vector SHALL occupy SETTLE+2 cycles; a START accepted at edge 0 SHALL produce DONE high in cycle 4*(SETTLE+2)+1.
REQ-024 REPORT: one cycle; DONE=1; PASS SHALL be set to (ERR_CNT==0 including the final sample); A=B=0 on exit; go to IDLE.
REQ-025 PASS, ERR_CNT and FAIL_MASK SHALL hold their values after REPORT until the next accepted START.
REQ-026 ERR_CNT SHALL never exceed 4 and SHALL not wrap.
REQ-027 START held continuously high SHALL start a new run on the cycle after returning to IDLE, and SHALL produce exactly one DONE per run.

Reset
REQ-028 RST_N low SHALL immediately, without waiting for CLK, force state IDLE, v=0, A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0 and FAIL_MASK=0, including mid-run.
REQ-029 A run interrupted by reset SHALL produce no DONE pulse.
REQ-030 After RST_N deasserts, the first START SHALL be honoured on the first rising edge of CLK at which it is high.

Verification
REQ-031 Reset mid-run: assert RST_N low between edges during the WAIT of vector 2 -> all outputs are 0 immediately, and no DONE follows.
REQ-032 SEL=1, X=A|B, SETTLE=2: (A,B) = 00, 01, 10, 11, each held 4 cycles -> DONE in cycle 17, PASS=1, ERR_CNT=0, FAIL_MASK=0000.
REQ-033 SEL=1, X stuck at 0 -> ERR_CNT=3, FAIL_MASK=1110, PASS=0.
REQ-034 SEL=4, X=A|B -> ERR_CNT=1, FAIL_MASK=1000, PASS=0.
REQ-035 SEL=2, X=~(A&B), START re-pulsed and SEL changed to 0 while BUSY -> exactly one DONE, PASS=1.
REQ-036 SETTLE=0, SEL=7, X=A -> DONE in cycle 9, PASS=1; previous FAIL_MASK is cleared on START.
